// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;
  localparam int ENTRY_W = PC_W + INSTR_W;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_is_aligned(input logic [PC_W-1:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

  // Widened by one bit so pc+3 near the top of the address space cannot wrap.
  function automatic logic pc_in_range(input logic [PC_W-1:0] pc,
                                       input logic [PC_W:0]   mem_bytes);
    return ({1'b0, pc} + 33'd3) < mem_bytes;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head entry is read straight from
// the storage registers so it stays stable until popped.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  logic [ENTRY_W-1:0]          i_push_data,
  input  logic                        i_pop,
  output logic [ENTRY_W-1:0]          o_head_data,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW:0]        r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_empty     = w_empty;
  assign o_count     = r_count;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, fills the prefetch queue from
// a combinational memory, handles redirects and flags sticky fetch faults.
// Decode handshake: an entry transfers in any cycle where out_valid and
// out_ready are both high; out_instr/out_pc hold steady while out_valid waits.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [PC_W:0]    MEM_LIMIT = (PC_W+1)'(MEM_BYTES);

  logic [PC_W-1:0] r_fetch_pc;
  logic            r_fault;
  logic [PC_W-1:0] r_fault_pc;

  logic               w_addr_ok;
  logic               w_fetch_ok;
  logic               w_pop;
  logic               w_push;
  logic               w_empty;
  logic [AW:0]        w_count;
  logic [ENTRY_W-1:0] w_head_data;
  fetch_entry_t       w_head;
  fetch_entry_t       w_new_entry;

  assign w_addr_ok  = pc_is_aligned(r_fetch_pc) & pc_in_range(r_fetch_pc, MEM_LIMIT);
  assign w_fetch_ok = ~r_fault & w_addr_ok;
  assign w_pop      = ~w_empty & out_ready;
  assign w_push     = w_fetch_ok & ((w_count < (AW+1)'(DEPTH)) | w_pop) & ~redirect_valid;

  assign w_new_entry.pc    = r_fetch_pc;
  assign w_new_entry.instr = imem_data;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_new_entry),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Redirect outranks everything: it restarts fetch and clears any fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_fault    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
      end
      if (!r_fault && !w_addr_ok) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_fetch_pc;
      end
    end
  end

  assign w_head    = fetch_entry_t'(w_head_data);
  assign imem_addr = r_fetch_pc;
  assign out_valid = ~w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: stimulus queues expected {pc, instr}
// pairs, an independent negedge monitor pops and compares every accepted entry.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 4;
  localparam int          MEM_BYTES = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_controller #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at byte address 4*k is (k+1) * 0x11111111.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  assign imem_data = (imem_addr < 32'(MEM_BYTES)) ? word_at(imem_addr) : 32'hDEAD_BEEF;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc + 32'(4 * i), word_at(pc + 32'(4 * i))});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
  endtask

  // Redirect, then let n entries from the target stream through to decode.
  task automatic redirect_stream(input logic [31:0] pc, input int n);
    exp_q.delete();
    expect_stream(pc, n);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 64'(out_valid), 64'd0);
    check("redir_fetch_pc", 64'(imem_addr), 64'(pc));
    check("redir_fault_clear", 64'(fault), 64'd0);
    repeat (n + 1) tick();
    out_ready = 1'b0;
    check("redir_stream_done", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_accept: got pc %0h instr %0h, nothing expected", out_pc, out_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("accept_pc_instr", {out_pc, out_instr}, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // 1: reset values, then streaming with no bubbles
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_fault_pc", 64'(fault_pc), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
    expect_stream(32'h0, 4);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_no_bubble", 64'(out_valid), 64'd1);
    end
    tick();
    out_ready = 1'b0;
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // 2: backpressure saturates the queue, then drains without gaps
    do_reset();
    out_ready = 1'b0;
    rst_n     = 1'b1;
    repeat (10) tick();
    check("t2_addr_hold", 64'(imem_addr), 64'd16);
    check("t2_head_valid", 64'(out_valid), 64'd1);
    check("t2_head_pc", 64'(out_pc), 64'd0);
    check("t2_head_instr", 64'(out_instr), 64'(word_at(32'h0)));
    expect_stream(32'h0, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_no_gap", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b0;
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: redirect while the queue holds pcs 8..20
    do_reset();
    out_ready = 1'b0;
    rst_n     = 1'b1;
    repeat (6) tick();
    expect_stream(32'h0, 2);
    out_ready = 1'b1;
    tick();
    tick();
    check("t3_head_before", 64'(out_pc), 64'd8);
    check("t3_addr_before", 64'(imem_addr), 64'd24);
    redirect_stream(32'h100, 2);

    // 4: run off the end of memory, fault, drain, recover
    redirect_stream(32'd1000, 6);
    for (int i = 0; i < 20 && !fault; i++) tick();
    check("t4_fault", 64'(fault), 64'd1);
    check("t4_fault_pc", 64'(fault_pc), 64'd1024);
    check("t4_drained_valid", 64'(out_valid), 64'd0);
    repeat (3) tick();
    check("t4_fault_sticky", 64'(fault), 64'd1);
    check("t4_fetch_stopped", 64'(imem_addr), 64'd1024);
    redirect_stream(32'h0, 2);

    // 5: misaligned redirect target
    exp_q.delete();
    out_ready      = 1'b1;
    redirect_pc    = 32'h102;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t5_fault_not_yet", 64'(fault), 64'd0);
    check("t5_valid_flush", 64'(out_valid), 64'd0);
    tick();
    check("t5_fault", 64'(fault), 64'd1);
    check("t5_fault_pc", 64'(fault_pc), 64'h102);
    check("t5_no_push", 64'(out_valid), 64'd0);
    repeat (3) tick();
    out_ready = 1'b0;

    // 6: asynchronous reset with a full queue
    redirect_stream(32'h0, 1);
    repeat (6) tick();
    check("t6_full_valid", 64'(out_valid), 64'd1);
    check("t6_head_pc", 64'(out_pc), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_pc", 64'(out_pc), 64'd0);
    check("t6_async_addr", 64'(imem_addr), 64'(RESET_PC));
    exp_q.delete();
    expect_stream(RESET_PC, 3);
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("t6_restart_drained", 64'(exp_q.size()), 64'd0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
